// File: rtl/spmm_ctrl_pkg.sv
// Shared types and defaults for the SPMM run controller.
package spmm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_WAIT_LOAD = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } spmm_sched_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DESYNC  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } spmm_err_code_e;

  localparam int DEF_W_NUM_OF_COLS  = 16;
  localparam int DEF_H_NUM_OF_ROWS  = 2708;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_CYC_CNT_WIDTH  = 32;

  // Counter width able to hold 0..max_rows inclusive.
  function automatic int row_cnt_width(input int max_rows);
    return $clog2(max_rows + 1);
  endfunction

  localparam int DEF_ROW_CNT_WIDTH = row_cnt_width(DEF_H_NUM_OF_ROWS);

endpackage

// File: rtl/spmm_watchdog.sv
// Clearable, enabled up-counter with a registered, sticky expiry flag.
// o_expired goes high on the cycle after TIMEOUT_CYCLES enabled cycles
// have elapsed since the last clear.
module spmm_watchdog
  import spmm_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expired;

  // Count enabled cycles; saturate at the threshold so the count never wraps.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (i_enable) begin
      if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) r_cnt <= r_cnt + CNT_W'(1);
      r_expired <= r_expired | (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/spmm_scheduler.sv
// Run controller for the sparse HxW multiply stage: waits for BRAM loads,
// soft-resets the datapath, drives valid, counts completed rows and flags
// completion, PE desynchronisation or stalled rows.
module spmm_scheduler
  import spmm_ctrl_pkg::*;
#(
  parameter int W_NUM_OF_COLS  = DEF_W_NUM_OF_COLS,
  parameter int H_NUM_OF_ROWS  = DEF_H_NUM_OF_ROWS,
  parameter int ROW_CNT_WIDTH  = row_cnt_width(H_NUM_OF_ROWS),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CYC_CNT_WIDTH  = DEF_CYC_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [ROW_CNT_WIDTH-1:0] num_rows_i,
  input  logic                     abort_i,
  input  logic                     h_load_done_i,
  input  logic                     w_load_done_i,
  input  logic [W_NUM_OF_COLS-1:0] pe_ready_i,
  input  logic                     done_ack_i,
  output logic                     spmm_valid_o,
  output logic                     spmm_srst_n_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [1:0]               err_code_o,
  output logic [ROW_CNT_WIDTH-1:0] rows_done_o,
  output logic [CYC_CNT_WIDTH-1:0] cycle_count_o
);

  spmm_sched_state_e        r_state;
  spmm_err_code_e           r_err_code;
  logic                     r_valid;
  logic                     r_srst_n;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic                     r_clr_last;
  logic [ROW_CNT_WIDTH-1:0] r_num_rows;
  logic [ROW_CNT_WIDTH-1:0] r_rows_done;
  logic [CYC_CNT_WIDTH-1:0] r_cycle_cnt;

  logic                     w_row_done;
  logic                     w_desync;
  logic                     w_in_run;
  logic                     w_wd_clear;
  logic                     w_wd_expired;
  logic [ROW_CNT_WIDTH-1:0] w_rows_done_inc;

  assign w_row_done      = &pe_ready_i;
  assign w_desync        = (|pe_ready_i) & ~w_row_done;
  assign w_in_run        = (r_state == ST_RUN);
  assign w_rows_done_inc = r_rows_done + ROW_CNT_WIDTH'(1);
  // Outside RUN the watchdog is held cleared, so every run starts from zero.
  assign w_wd_clear      = ~w_in_run | w_row_done;

  spmm_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_wd_clear),
    .i_enable (w_in_run),
    .o_expired(w_wd_expired)
  );

  // Run-control FSM; every output is registered alongside its state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_err_code  <= ERR_NONE;
      r_valid     <= 1'b0;
      r_srst_n    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_clr_last  <= 1'b0;
      r_num_rows  <= '0;
      r_rows_done <= '0;
      r_cycle_cnt <= '0;
    end else if (abort_i) begin
      // Counters are deliberately left alone so software can read them back.
      r_state    <= ST_IDLE;
      r_err_code <= ERR_NONE;
      r_valid    <= 1'b0;
      r_srst_n   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_clr_last <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_busy <= 1'b1;
            if (num_rows_i != '0) begin
              r_state     <= ST_CLEAR;
              r_num_rows  <= num_rows_i;
              r_rows_done <= '0;
              r_cycle_cnt <= '0;
              r_srst_n    <= 1'b0;
              r_clr_last  <= 1'b0;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          // Two-cycle soft reset: first cycle arms r_clr_last, second exits.
          if (r_clr_last) begin
            r_state    <= ST_WAIT_LOAD;
            r_srst_n   <= 1'b1;
            r_clr_last <= 1'b0;
          end else begin
            r_clr_last <= 1'b1;
          end
        end
        ST_WAIT_LOAD: begin
          if (h_load_done_i && w_load_done_i) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + CYC_CNT_WIDTH'(1);
          if (w_row_done) begin
            r_rows_done <= w_rows_done_inc;
            if (w_rows_done_inc == r_num_rows) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (w_desync) begin
            r_state    <= ST_ERROR;
            r_valid    <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= ERR_DESYNC;
          end else if (w_wd_expired) begin
            r_state    <= ST_ERROR;
            r_valid    <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
        end
        ST_DONE: begin
          if (done_ack_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_ERROR: begin
          // Held until abort or reset.
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign spmm_valid_o  = r_valid;
  assign spmm_srst_n_o = r_srst_n;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign error_o       = r_error;
  assign err_code_o    = r_err_code;
  assign rows_done_o   = r_rows_done;
  assign cycle_count_o = r_cycle_cnt;

endmodule

// File: tb/tb_spmm_scheduler.sv
// Self-checking bench for spmm_scheduler. Inputs change and outputs are
// sampled on the falling edge; expectations come from counting rules.
module tb_spmm_scheduler;
  import spmm_ctrl_pkg::*;

  localparam int W   = 16;
  localparam int RW  = DEF_ROW_CNT_WIDTH;
  localparam int CW  = 32;
  localparam int TMO = 8;

  // Status word layout: {busy, valid, srst_n, done, error, err_code[1:0]}
  localparam logic [6:0] S_IDLE  = 7'b0010000;
  localparam logic [6:0] S_CLEAR = 7'b1000000;
  localparam logic [6:0] S_WAIT  = 7'b1010000;
  localparam logic [6:0] S_RUN   = 7'b1110000;
  localparam logic [6:0] S_DONE  = 7'b1011000;
  localparam logic [6:0] S_EDSY  = 7'b1010101;
  localparam logic [6:0] S_ETMO  = 7'b1010110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [RW-1:0] num_rows_i = '0;
  logic          abort_i = 1'b0;
  logic          h_load_done_i = 1'b0;
  logic          w_load_done_i = 1'b0;
  logic [W-1:0]  pe_ready_i = '0;
  logic          done_ack_i = 1'b0;
  logic          spmm_valid_o, spmm_srst_n_o, busy_o, done_o, error_o;
  logic [1:0]    err_code_o;
  logic [RW-1:0] rows_done_o;
  logic [CW-1:0] cycle_count_o;

  int n_vec = 0;
  int n_err = 0;
  int pulses[$];

  always #5 clk = ~clk;

  spmm_scheduler #(
    .W_NUM_OF_COLS (W),
    .TIMEOUT_CYCLES(TMO),
    .CYC_CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .num_rows_i   (num_rows_i),
    .abort_i      (abort_i),
    .h_load_done_i(h_load_done_i),
    .w_load_done_i(w_load_done_i),
    .pe_ready_i   (pe_ready_i),
    .done_ack_i   (done_ack_i),
    .spmm_valid_o (spmm_valid_o),
    .spmm_srst_n_o(spmm_srst_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .err_code_o   (err_code_o),
    .rows_done_o  (rows_done_o),
    .cycle_count_o(cycle_count_o)
  );

  function automatic logic [6:0] status();
    return {busy_o, spmm_valid_o, spmm_srst_n_o, done_o, error_o, err_code_o};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start(input int n);
    start_i    = 1'b1;
    num_rows_i = RW'(n);
    cyc();
    start_i    = 1'b0;
  endtask

  // Start with loads already high; returns at the first visible RUN cycle.
  task automatic enter_run(input int n);
    h_load_done_i = 1'b1;
    w_load_done_i = 1'b1;
    pe_ready_i    = '0;
    do_start(n);
    repeat (3) cyc();
  endtask

  // Full run: row_done at the RUN indices held in 'pulses' (last = final row).
  task automatic drive_run(input string tag, input int n, input int hd, input int wd);
    int m, seen, last;
    bit hit;
    m    = (hd > wd) ? hd : wd;
    last = pulses[pulses.size()-1];
    h_load_done_i = (hd == 0);
    w_load_done_i = (wd == 0);
    pe_ready_i    = '0;
    do_start(n);
    if (status() !== S_CLEAR) begin
      $display("FAIL %s_clear1: got %b want %b", tag, status(), S_CLEAR); n_err++;
    end
    n_vec++;
    cyc();
    if (status() !== S_CLEAR) begin
      $display("FAIL %s_clear2: got %b want %b", tag, status(), S_CLEAR); n_err++;
    end
    n_vec++;
    cyc();
    if ({status(), rows_done_o, cycle_count_o} !== {S_WAIT, RW'(0), CW'(0)}) begin
      $display("FAIL %s_wait_entry: got %b/%0d/%0d want %b/0/0", tag, status(),
               rows_done_o, cycle_count_o, S_WAIT); n_err++;
    end
    n_vec++;
    for (int j = 0; ; j++) begin
      h_load_done_i = (j >= hd);
      w_load_done_i = (j >= wd);
      cyc();
      if (j >= m) break;
      if (status() !== S_WAIT) begin
        $display("FAIL %s_wait%0d: got %b want %b", tag, j, status(), S_WAIT); n_err++;
      end
      n_vec++;
    end
    if (status() !== S_RUN) begin
      $display("FAIL %s_run_entry: got %b want %b", tag, status(), S_RUN); n_err++;
    end
    n_vec++;
    seen = 0;
    for (int k = 0; k <= last; k++) begin
      hit = (seen < pulses.size()) && (pulses[seen] == k);
      pe_ready_i = hit ? '1 : '0;
      // Load-done dropping mid-run must be ignored.
      h_load_done_i = 1'($urandom_range(0, 1));
      cyc();
      if (hit) seen++;
      pe_ready_i = '0;
      if ({status(), rows_done_o, cycle_count_o} !==
          {(k == last) ? S_DONE : S_RUN, RW'(seen), CW'(k + 1)}) begin
        $display("FAIL %s_run%0d: got %b/%0d/%0d want %b/%0d/%0d", tag, k, status(),
                 rows_done_o, cycle_count_o, (k == last) ? S_DONE : S_RUN, seen, k + 1);
        n_err++;
      end
      n_vec++;
    end
    repeat ($urandom_range(1, 4)) begin
      pe_ready_i = W'($urandom);
      start_i    = 1'($urandom_range(0, 1));
      cyc();
      if ({status(), rows_done_o} !== {S_DONE, RW'(n)}) begin
        $display("FAIL %s_done_hold: got %b/%0d want %b/%0d", tag, status(), rows_done_o,
                 S_DONE, n); n_err++;
      end
      n_vec++;
    end
    start_i    = 1'b0;
    pe_ready_i = '0;
    done_ack_i = 1'b1;
    cyc();
    done_ack_i = 1'b0;
    if ({status(), rows_done_o, cycle_count_o} !== {S_IDLE, RW'(n), CW'(last + 1)}) begin
      $display("FAIL %s_ack: got %b/%0d/%0d want %b/%0d/%0d", tag, status(), rows_done_o,
               cycle_count_o, S_IDLE, n, last + 1); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    if ({status(), rows_done_o, cycle_count_o} !== {S_IDLE, RW'(0), CW'(0)}) begin
      $display("FAIL reset_values: got %b/%0d/%0d want %b/0/0", status(), rows_done_o,
               cycle_count_o, S_IDLE); n_err++;
    end
    n_vec++;
    rst_n = 1'b1;
    cyc();
    if (status() !== S_IDLE) begin
      $display("FAIL reset_release: got %b want %b", status(), S_IDLE); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_normal_run();
    pulses = '{5, 9, 13};
    drive_run("normal", 3, 0, 0);
  endtask

  task automatic test_load_gating();
    pulses = '{4};
    drive_run("loadgate", 1, 2, 12);
  endtask

  task automatic test_zero_rows();
    h_load_done_i = 1'b1;
    w_load_done_i = 1'b1;
    do_start(0);
    for (int i = 0; i < 3; i++) begin
      if (status() !== S_DONE) begin
        $display("FAIL zero_rows_done%0d: got %b want %b", i, status(), S_DONE); n_err++;
      end
      n_vec++;
      cyc();
    end
    done_ack_i = 1'b1;
    cyc();
    done_ack_i = 1'b0;
    if (status() !== S_IDLE) begin
      $display("FAIL zero_rows_ack: got %b want %b", status(), S_IDLE); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_desync();
    enter_run(4);
    for (int k = 0; k <= 4; k++) begin
      pe_ready_i = (k == 2) ? '1 : ((k == 4) ? 16'h00FF : '0);
      cyc();
    end
    if ({status(), rows_done_o, cycle_count_o} !== {S_EDSY, RW'(1), CW'(5)}) begin
      $display("FAIL desync_error: got %b/%0d/%0d want %b/1/5", status(), rows_done_o,
               cycle_count_o, S_EDSY); n_err++;
    end
    n_vec++;
    // Error is sticky: start and full ready vectors are ignored here.
    start_i    = 1'b1;
    pe_ready_i = '1;
    repeat (3) cyc();
    start_i    = 1'b0;
    pe_ready_i = '0;
    if ({status(), rows_done_o} !== {S_EDSY, RW'(1)}) begin
      $display("FAIL desync_sticky: got %b/%0d want %b/1", status(), rows_done_o, S_EDSY);
      n_err++;
    end
    n_vec++;
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    if ({status(), rows_done_o, cycle_count_o} !== {S_IDLE, RW'(1), CW'(5)}) begin
      $display("FAIL desync_abort: got %b/%0d/%0d want %b/1/5", status(), rows_done_o,
               cycle_count_o, S_IDLE); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_timeout();
    enter_run(2);
    for (int k = 1; k <= TMO; k++) begin
      cyc();
      if (status() !== S_RUN) begin
        $display("FAIL timeout_early%0d: got %b want %b", k, status(), S_RUN); n_err++;
      end
      n_vec++;
    end
    cyc();
    if ({status(), cycle_count_o} !== {S_ETMO, CW'(TMO + 1)}) begin
      $display("FAIL timeout_error: got %b/%0d want %b/%0d", status(), cycle_count_o,
               S_ETMO, TMO + 1); n_err++;
    end
    n_vec++;
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    if (status() !== S_IDLE) begin
      $display("FAIL timeout_abort: got %b want %b", status(), S_IDLE); n_err++;
    end
    n_vec++;
    // row_done on the threshold cycle wins over the timeout.
    enter_run(2);
    repeat (TMO) cyc();
    pe_ready_i = '1;
    cyc();
    pe_ready_i = '0;
    repeat (3) cyc();
    if ({status(), rows_done_o} !== {S_RUN, RW'(1)}) begin
      $display("FAIL timeout_threshold_row: got %b/%0d want %b/1", status(), rows_done_o,
               S_RUN); n_err++;
    end
    n_vec++;
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    enter_run(4);
    for (int k = 0; k <= 3; k++) begin
      pe_ready_i = (k == 1 || k == 3) ? '1 : '0;
      cyc();
    end
    pe_ready_i = '0;
    if ({status(), rows_done_o} !== {S_RUN, RW'(2)}) begin
      $display("FAIL midreset_pre: got %b/%0d want %b/2", status(), rows_done_o, S_RUN);
      n_err++;
    end
    n_vec++;
    #2 rst_n = 1'b0;
    #1;
    if ({status(), rows_done_o, cycle_count_o} !== {S_IDLE, RW'(0), CW'(0)}) begin
      $display("FAIL midreset_async: got %b/%0d/%0d want %b/0/0", status(), rows_done_o,
               cycle_count_o, S_IDLE); n_err++;
    end
    n_vec++;
    cyc();
    rst_n = 1'b1;
    cyc();
    pulses = '{2, 6};
    drive_run("after_reset", 2, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      int n, p;
      n = $urandom_range(1, 5);
      pulses.delete();
      p = -1;
      for (int i = 0; i < n; i++) begin
        p += $urandom_range(1, TMO - 1);
        pulses.push_back(p);
      end
      drive_run($sformatf("rand%0d", r), n, $urandom_range(0, 4), $urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_zero_rows();
    test_load_gating();
    test_desync();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no end of run, want completion");
    $fatal(1, "time limit");
  end

endmodule
